cim_bus_arbiter: RTL and testbench

CIM_BUS_ARBITER -- requirements
Module: cim_bus_arbiter

---
 rtl/cim_bus_arbiter_if.sv | 47 ++++
 rtl/cim_bus_arbiter.sv | 117 +++++++++++
 tb/tb_cim_bus_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cim_bus_arbiter_if.sv
// Shared CIM bus signal bundle: master/CIM requests and grants plus the registered broadcast bus.
// bus_parity exists only when CIM_BUS_PARITY_EN is defined.
interface cim_bus_arbiter_if #(
  parameter int unsigned NUM_CIMS = 64,
  parameter int unsigned DATA_W   = 22,
  parameter int unsigned OP_W     = 4
);
  localparam int unsigned ID_W = $clog2(NUM_CIMS);

  logic                       master_req;
  logic [OP_W-1:0]            master_op;
  logic [DATA_W-1:0]          master_data;
  logic [ID_W-1:0]            master_target;
  logic                       master_gnt;
  logic [NUM_CIMS-1:0]        cim_req;
  logic [NUM_CIMS*OP_W-1:0]   cim_op;
  logic [NUM_CIMS*DATA_W-1:0] cim_data;
  logic [NUM_CIMS-1:0]        cim_gnt;
  logic [NUM_CIMS-1:0]        cim_is_ready;
  logic                       all_cims_ready;
  logic [OP_W-1:0]            bus_op;
  logic [DATA_W-1:0]          bus_data;
  logic [ID_W-1:0]            bus_target_or_sender;
`ifdef CIM_BUS_PARITY_EN
  logic                       bus_parity;
`endif

  // Arbiter side.
  modport slave (
    input  master_req, master_op, master_data, master_target, cim_req, cim_op, cim_data,
           cim_is_ready,
    output master_gnt, cim_gnt, all_cims_ready, bus_op, bus_data, bus_target_or_sender
`ifdef CIM_BUS_PARITY_EN
    , output bus_parity
`endif
  );

  // Requester / observer side.
  modport master (
    output master_req, master_op, master_data, master_target, cim_req, cim_op, cim_data,
           cim_is_ready,
    input  master_gnt, cim_gnt, all_cims_ready, bus_op, bus_data, bus_target_or_sender
`ifdef CIM_BUS_PARITY_EN
    , input bus_parity
`endif
  );
endinterface

// File: rtl/cim_bus_arbiter.sv
// Shared-bus arbiter: master priority with bounded burst under CIM contention, round-robin CIMs.
// Define CIM_BUS_PARITY_EN to add a registered even-parity bit over the broadcast bus.
module cim_bus_arbiter #(
  parameter int unsigned NUM_CIMS  = 64,
  parameter int unsigned DATA_W    = 22,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst_n,
  cim_bus_arbiter_if.slave  bus_io
);
  localparam int unsigned ID_W  = $clog2(NUM_CIMS);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StMaster, StCim} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [OP_W-1:0]    bus_op_q, bus_op_d;
  logic [DATA_W-1:0]  bus_data_q, bus_data_d;
  logic [ID_W-1:0]    bus_sender_q, bus_sender_d;
  logic               all_ready_q;
  logic               any_cim, burst_full, master_win, cim_win, cim_found;
  logic [ID_W-1:0]    cim_idx;
  logic [ID_W:0]      cand;
  logic [NUM_CIMS-1:0] cim_gnt;

  // Round-robin search starting at rr_ptr_q, wrapping at NUM_CIMS.
  always_comb begin
    cim_found = 1'b0;
    cim_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CIMS; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_CIMS)) cand = cand - (ID_W + 1)'(NUM_CIMS);
      if (!cim_found && bus_io.cim_req[cand[ID_W-1:0]]) begin
        cim_found = 1'b1;
        cim_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    any_cim    = |bus_io.cim_req;
    burst_full = (burst_cnt_q == CNT_W'(MAX_BURST));
    master_win = rst_n && bus_io.master_req && !(burst_full && any_cim);
    cim_win    = rst_n && !master_win && cim_found;
    cim_gnt    = '0;
    if (cim_win) cim_gnt[cim_idx] = 1'b1;
  end

  always_comb begin
    state_d      = StIdle;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    bus_op_d     = '0;
    bus_data_d   = '0;
    bus_sender_d = '0;
    if (master_win) begin
      state_d      = StMaster;
      bus_op_d     = bus_io.master_op;
      bus_data_d   = bus_io.master_data;
      bus_sender_d = bus_io.master_target;
      if (any_cim && !burst_full) burst_cnt_d = burst_cnt_q + 1'b1;
    end else if (cim_win) begin
      state_d      = StCim;
      bus_op_d     = bus_io.cim_op[cim_idx*OP_W +: OP_W];
      bus_data_d   = bus_io.cim_data[cim_idx*DATA_W +: DATA_W];
      bus_sender_d = cim_idx;
      rr_ptr_d     = (cim_idx == ID_W'(NUM_CIMS - 1)) ? '0 : cim_idx + 1'b1;
      burst_cnt_d  = '0;
    end
    if (!any_cim) burst_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      burst_cnt_q  <= '0;
      bus_op_q     <= '0;
      bus_data_q   <= '0;
      bus_sender_q <= '0;
      all_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      bus_op_q     <= bus_op_d;
      bus_data_q   <= bus_data_d;
      bus_sender_q <= bus_sender_d;
      all_ready_q  <= &bus_io.cim_is_ready;
    end
  end

  // An idle cycle must leave an all-zero bus behind it.
  idle_bus_zero: assert property (@(posedge clk)
      (state_q == StIdle) |-> (bus_op_q == '0 && bus_data_q == '0 && bus_sender_q == '0));

  assign bus_io.master_gnt           = master_win;
  assign bus_io.cim_gnt              = cim_gnt;
  assign bus_io.all_cims_ready       = all_ready_q;
  assign bus_io.bus_op               = bus_op_q;
  assign bus_io.bus_data             = bus_data_q;
  assign bus_io.bus_target_or_sender = bus_sender_q;

`ifdef CIM_BUS_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^{bus_op_d, bus_data_d, bus_sender_d};
  end
  assign bus_io.bus_parity = parity_q;
`endif
endmodule

// File: tb/tb_cim_bus_arbiter.sv
// Randomized scoreboard bench for cim_bus_arbiter with directed scenarios up front.
// Exercises bus_parity as well when CIM_BUS_PARITY_EN is defined.
module tb_cim_bus_arbiter;
  localparam int unsigned NC = 4;
  localparam int unsigned DW = 22;
  localparam int unsigned OW = 4;
  localparam int unsigned MB = 8;
  localparam int unsigned IW = $clog2(NC);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cim_bus_arbiter_if #(.NUM_CIMS(NC), .DATA_W(DW), .OP_W(OW)) bif ();

  cim_bus_arbiter #(.NUM_CIMS(NC), .DATA_W(DW), .OP_W(OW), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bif)
  );

  int checks = 0;
  int errors = 0;

  // Expected grant {master_gnt, cim_gnt} and expected bus {all_ready, op, data, sender}.
  logic [NC:0]            gnt_q[$];
  logic [1+OW+DW+IW-1:0]  bus_q[$];

  // Reference model state: plain integers, not the RTL encoding.
  int m_rr = 0;
  int m_burst = 0;
  int last_owner = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle. Inputs were driven at the preceding negedge; returns at the next negedge.
  task automatic step();
    int owner;
    bit any;
    logic [NC-1:0] cg;
    logic [OW-1:0] op;
    logic [DW-1:0] dat;
    logic [IW-1:0] snd;
    logic acr;
    any   = |bif.cim_req;
    owner = -1;
    if (rst_n) begin
      if (bif.master_req && !(m_burst == MB && any)) owner = -2;
      else begin
        for (int k = 0; k < NC; k++) begin
          int i;
          i = (m_rr + k) % NC;
          if (owner == -1 && bif.cim_req[i]) owner = i;
        end
      end
    end
    cg = '0;
    if (owner >= 0) cg[owner] = 1'b1;
    gnt_q.push_back({owner == -2, cg});
    op = '0; dat = '0; snd = '0;
    if (owner == -2) begin
      op = bif.master_op; dat = bif.master_data; snd = bif.master_target;
    end else if (owner >= 0) begin
      op  = bif.cim_op[owner*OW +: OW];
      dat = bif.cim_data[owner*DW +: DW];
      snd = IW'(owner);
    end
    acr = rst_n ? &bif.cim_is_ready : 1'b0;
    if (!rst_n) begin
      m_rr = 0; m_burst = 0;
    end else begin
      if (owner >= 0) m_rr = (owner + 1) % NC;
      if (!any || owner >= 0) m_burst = 0;
      else if (owner == -2 && m_burst < MB) m_burst++;
    end
    last_owner = owner;
    @(posedge clk);
    bus_q.push_back({acr, op, dat, snd});
    @(negedge clk);
  endtask

  // Monitor: bus outputs shortly after negedge, grants just before posedge.
  initial begin
    logic [NC:0] eg;
    logic [1+OW+DW+IW-1:0] eb;
    forever begin
      @(negedge clk);
      #2;
      if (bus_q.size() > 0) begin
        eb = bus_q.pop_front();
        chk("all_cims_ready", 64'(bif.all_cims_ready), 64'(eb[OW+DW+IW]));
        chk("bus_op", 64'(bif.bus_op), 64'(eb[OW+DW+IW-1 -: OW]));
        chk("bus_data", 64'(bif.bus_data), 64'(eb[DW+IW-1 -: DW]));
        chk("bus_sender", 64'(bif.bus_target_or_sender), 64'(eb[IW-1:0]));
`ifdef CIM_BUS_PARITY_EN
        chk("bus_parity", 64'(bif.bus_parity), 64'(^eb[OW+DW+IW-1:0]));
`endif
      end
      #2;
      if (gnt_q.size() > 0) begin
        eg = gnt_q.pop_front();
        chk("master_gnt", 64'(bif.master_gnt), 64'(eg[NC]));
        chk("cim_gnt", 64'(bif.cim_gnt), 64'(eg[NC-1:0]));
      end
    end
  end

  task automatic rand_cim(input int i);
    bif.cim_req[i]           = 1'($urandom_range(0, 1));
    bif.cim_op[i*OW +: OW]   = OW'($urandom);
    bif.cim_data[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.master_req = 1'b1; bif.master_op = 4'h7; bif.master_data = 22'h12345;
    bif.master_target = 2'd1;
    bif.cim_req = 4'b1011; bif.cim_is_ready = '1;
    for (int i = 0; i < NC; i++) begin
      bif.cim_op[i*OW +: OW]   = OW'(i + 1);
      bif.cim_data[i*DW +: DW] = DW'($urandom);
    end
    @(negedge clk);
    // Requests during reset get no grant.
    step(); step();
    rst_n = 1'b1; bif.master_req = 1'b0; bif.cim_req = '0;
    step();
    // All CIMs requesting: strict 0,1,2,3 rotation.
    bif.cim_req = 4'b1111;
    repeat (8) step();
    bif.cim_req = '0;
    step();
    // Master vs. CIM 2: eight master grants, then CIM 2, then master again.
    bif.master_req = 1'b1; bif.cim_req = 4'b0100;
    repeat (9) step();
    bif.cim_req = '0;
    step();
    // Master alone never yields.
    bif.master_target = 2'd5 % NC; bif.master_target = 2'(5); bif.master_data = 22'h3FFFFF;
    bif.master_op = 4'h1;
    repeat (20) step();
    // Move rr_ptr to 3 mid-burst, then reset for one cycle.
    bif.master_req = 1'b0; bif.cim_req = 4'b1111;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    bif.cim_req = '0;
    // all_cims_ready lags the last ready bit by one cycle.
    bif.cim_is_ready = 4'b1101;
    repeat (3) step();
    bif.cim_is_ready = 4'b1111;
    repeat (3) step();
    // Parity pattern: op=1, data=3, sender=0.
    bif.master_req = 1'b1; bif.master_op = 4'h1; bif.master_data = 22'h3;
    bif.master_target = '0;
    step();
    bif.master_req = 1'b0;
    step();
    // Randomized traffic; requesters hold until granted.
    for (int n = 0; n < 600; n++) begin
      if (last_owner == -2 || !bif.master_req) begin
        bif.master_req    = ($urandom_range(0, 9) < 8);
        bif.master_op     = OW'($urandom);
        bif.master_data   = DW'($urandom);
        bif.master_target = IW'($urandom);
      end
      for (int i = 0; i < NC; i++)
        if (last_owner == i || !bif.cim_req[i]) rand_cim(i);
      bif.cim_is_ready = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '1;
      step();
    end
    bif.master_req = 1'b0; bif.cim_req = '0;
    repeat (3) step();
    repeat (2) @(negedge clk);
    checks++;
    if (gnt_q.size() != 0 || bus_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d left, expected 0/0", gnt_q.size(), bus_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
